// File: rtl/run_feeder.sv
// run_feeder
// ----------
// Writer side of the merge-cell input protocol. Pre-sorted runs arrive on a
// valid/ready stream. Each run is written to one of the two lane FIFOs (A or
// B), and a zero terminator is appended after it. Successive runs alternate
// between the lanes, starting with A. A flush closes any open run. It then
// pads the lagging lane with one empty run, so that both lanes end on a
// terminator, and the block parks in DONE until reset.
//
// Handshake: a record transfers on a rising edge where i_valid & o_ready.
// o_ready depends only on state, lane and the current lane's almost-full
// flag. It never depends on i_valid. Once i_valid is raised, the source must
// hold i_data/i_last steady until the transfer.
//
// Configuration macro: RUN_FEEDER_ORDER_CHECK_EN
//   Defined: a nonzero record smaller than the previous record of the same
//   open run is still written, but it sets o_err.
//   Undefined: o_err only reports dropped zero records.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_data/i_valid/i_last input record stream, o_ready back-pressure
//   i_flush               end-of-input pulse
//   i_a_full/i_b_full     lane FIFO almost-full (<=1 slot free)
//   o_a_data/o_a_wr       lane-A write port (registered)
//   o_b_data/o_b_wr       lane-B write port (registered)
//   o_runs_a/o_runs_b     terminated runs written per lane (wrapping)
//   o_done                flush complete, sticky
//   o_err                 sticky error flag
module run_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  input  logic                  i_last,
  output logic                  o_ready,
  input  logic                  i_flush,
  input  logic                  i_a_full,
  input  logic                  i_b_full,
  output logic [DATA_WIDTH-1:0] o_a_data,
  output logic                  o_a_wr,
  output logic [DATA_WIDTH-1:0] o_b_data,
  output logic                  o_b_wr,
  output logic [CNT_WIDTH-1:0]  o_runs_a,
  output logic [CNT_WIDTH-1:0]  o_runs_b,
  output logic                  o_done,
  output logic                  o_err
);

  typedef enum logic [1:0] {
    ST_STREAM = 2'd0,
    ST_TERM   = 2'd1,
    ST_PAD    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q;
  logic                  lane_q;        // 0 = lane A, 1 = lane B
  logic                  open_q;        // records accepted in the current run, no i_last yet
  logic                  flush_pend_q;
  logic [DATA_WIDTH-1:0] a_data_q, b_data_q;
  logic                  a_wr_q, b_wr_q;
  logic [CNT_WIDTH-1:0]  runs_a_q, runs_b_q;
  logic                  done_q, err_q;

`ifdef RUN_FEEDER_ORDER_CHECK_EN
  // The open run always lives on one lane, so a single tracker covers the
  // lane being written. It is invalidated at every terminator.
  logic [DATA_WIDTH-1:0] prev_q;
  logic                  prev_vld_q;
`endif

  logic lane_full;
  logic accept;
  logic flush_hit;

  assign lane_full = lane_q ? i_b_full : i_a_full;
  // i_rst gating keeps o_ready low during the reset cycle itself.
  assign o_ready   = (state_q == ST_STREAM) & ~lane_full & ~i_rst;
  assign accept    = i_valid & o_ready;
  assign flush_hit = i_flush | flush_pend_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_STREAM;
      lane_q       <= 1'b0;
      open_q       <= 1'b0;
      flush_pend_q <= 1'b0;
      a_data_q     <= '0;
      b_data_q     <= '0;
      a_wr_q       <= 1'b0;
      b_wr_q       <= 1'b0;
      runs_a_q     <= '0;
      runs_b_q     <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef RUN_FEEDER_ORDER_CHECK_EN
      prev_q       <= '0;
      prev_vld_q   <= 1'b0;
`endif
    end else begin
      a_wr_q <= 1'b0;
      b_wr_q <= 1'b0;
      case (state_q)
        ST_STREAM: begin
          if (accept) begin
            if (i_data != '0) begin
              if (lane_q) begin
                b_wr_q   <= 1'b1;
                b_data_q <= i_data;
              end else begin
                a_wr_q   <= 1'b1;
                a_data_q <= i_data;
              end
`ifdef RUN_FEEDER_ORDER_CHECK_EN
              if (prev_vld_q && (i_data < prev_q)) err_q <= 1'b1;
              prev_q     <= i_data;
              prev_vld_q <= 1'b1;
`endif
            end else begin
              // Zero is reserved as the terminator. Drop it, but keep i_last.
              err_q <= 1'b1;
            end
            if (i_last) begin
              state_q      <= ST_TERM;
              open_q       <= 1'b0;
              flush_pend_q <= flush_hit;
            end else begin
              open_q <= 1'b1;
              // A flush arriving with a record closes the run just extended.
              if (flush_hit) begin
                state_q      <= ST_TERM;
                flush_pend_q <= 1'b1;
              end
            end
          end else if (flush_hit) begin
            if (open_q) begin
              state_q      <= ST_TERM;
              flush_pend_q <= 1'b1;
            end else begin
              state_q      <= ST_PAD;
              flush_pend_q <= 1'b0;
            end
          end
        end

        ST_TERM: begin
          if (i_flush) flush_pend_q <= 1'b1;
          if (!lane_full) begin
            if (lane_q) begin
              b_wr_q   <= 1'b1;
              b_data_q <= '0;
              runs_b_q <= runs_b_q + CNT_ONE;
            end else begin
              a_wr_q   <= 1'b1;
              a_data_q <= '0;
              runs_a_q <= runs_a_q + CNT_ONE;
            end
            lane_q <= ~lane_q;
            open_q <= 1'b0;
`ifdef RUN_FEEDER_ORDER_CHECK_EN
            prev_vld_q <= 1'b0;
`endif
            if (flush_hit) begin
              state_q      <= ST_PAD;
              flush_pend_q <= 1'b0;
            end else begin
              state_q <= ST_STREAM;
            end
          end
        end

        ST_PAD: begin
          // Lanes alternate from A, so unequal counters always mean the lane
          // pointer sits on the lagging lane (B). This holds across wrap.
          if (runs_a_q != runs_b_q) begin
            if (!lane_full) begin
              if (lane_q) begin
                b_wr_q   <= 1'b1;
                b_data_q <= '0;
                runs_b_q <= runs_b_q + CNT_ONE;
              end else begin
                a_wr_q   <= 1'b1;
                a_data_q <= '0;
                runs_a_q <= runs_a_q + CNT_ONE;
              end
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end else begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end

        ST_DONE: begin
          // Parked until reset. Stream and flush inputs are ignored.
        end

        default: state_q <= ST_STREAM;
      endcase
    end
  end

  assign o_a_data = a_data_q;
  assign o_a_wr   = a_wr_q;
  assign o_b_data = b_data_q;
  assign o_b_wr   = b_wr_q;
  assign o_runs_a = runs_a_q;
  assign o_runs_b = runs_b_q;
  assign o_done   = done_q;
  assign o_err    = err_q;

endmodule

// File: tb/tb_run_feeder.sv
`timescale 1ns/1ps
module tb_run_feeder;

  logic        clk;
  logic        rst;
  logic [31:0] i_data;
  logic        i_valid, i_last, i_flush, i_a_full, i_b_full;
  logic        o_ready, o_a_wr, o_b_wr, o_done, o_err;
  logic [31:0] o_a_data, o_b_data;
  logic [15:0] o_runs_a, o_runs_b;

  run_feeder #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(i_data), .i_valid(i_valid), .i_last(i_last),
    .o_ready(o_ready), .i_flush(i_flush), .i_a_full(i_a_full), .i_b_full(i_b_full),
    .o_a_data(o_a_data), .o_a_wr(o_a_wr), .o_b_data(o_b_data), .o_b_wr(o_b_wr),
    .o_runs_a(o_runs_a), .o_runs_b(o_runs_b), .o_done(o_done), .o_err(o_err)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [31:0] got_a_q[$], got_b_q[$];
  logic [31:0] exp_a_q[$], exp_b_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          both_wr_seen = 1'b0;

  always @(negedge clk) begin
    if (o_a_wr === 1'b1) got_a_q.push_back(o_a_data);
    if (o_b_wr === 1'b1) got_b_q.push_back(o_b_data);
    if (o_a_wr === 1'b1 && o_b_wr === 1'b1) both_wr_seen = 1'b1;
  end

  function automatic bit q_eq(input logic [31:0] a[$], input logic [31:0] b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_q();
    got_a_q.delete(); got_b_q.delete(); exp_a_q.delete(); exp_b_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_a_full = 1'b0; i_b_full = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    i_valid = 1'b1; i_data = d; i_last = l;
    #1;
    while (o_ready !== 1'b1 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (o_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_timeout data %0d ready %b", d, o_ready);
    end else begin
      @(posedge clk); #1;
    end
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_a_full = 1'b0; i_b_full = 1'b0;
    i_data = '0; i_last = 1'b0;
    #1;
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_first got %b exp 0", o_ready); end
    @(negedge clk);
    checks++; if ({o_a_wr, o_b_wr, o_done, o_err} !== 4'b0000) begin errors++;
      $display("FAIL reset_flags got %b exp 0000", {o_a_wr, o_b_wr, o_done, o_err}); end
    checks++; if (o_runs_a !== 16'd0 || o_runs_b !== 16'd0) begin errors++;
      $display("FAIL reset_runs got %0d/%0d exp 0/0", o_runs_a, o_runs_b); end
    checks++; if (o_a_data !== 32'd0 || o_b_data !== 32'd0) begin errors++;
      $display("FAIL reset_data got %0d/%0d exp 0/0", o_a_data, o_b_data); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_held got %b exp 0", o_ready); end
    rst = 1'b0;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %b exp 1", o_ready); end
  endtask

  task automatic test_basic();
    clear_q();
    send(32'd3, 1'b0); send(32'd5, 1'b0); send(32'd9, 1'b1);
    idle(4);
    exp_a_q = '{32'd3, 32'd5, 32'd9, 32'd0};
    checks++; if (!q_eq(got_a_q, exp_a_q)) begin errors++;
      $display("FAIL basic_lane_a got %0d words exp %0d words", got_a_q.size(), exp_a_q.size()); end
    checks++; if (got_b_q.size() != 0) begin errors++; $display("FAIL basic_lane_b_idle got %0d words exp 0", got_b_q.size()); end
    checks++; if (o_runs_a !== 16'd1 || o_runs_b !== 16'd0) begin errors++;
      $display("FAIL basic_runs1 got %0d/%0d exp 1/0", o_runs_a, o_runs_b); end
    send(32'd2, 1'b1);
    idle(4);
    exp_b_q = '{32'd2, 32'd0};
    checks++; if (!q_eq(got_b_q, exp_b_q)) begin errors++;
      $display("FAIL basic_lane_b got %0d words exp %0d words", got_b_q.size(), exp_b_q.size()); end
    checks++; if (o_runs_b !== 16'd1) begin errors++; $display("FAIL basic_runs_b got %0d exp 1", o_runs_b); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL basic_err got %b exp 0", o_err); end
  endtask

  task automatic test_backpressure();
    clear_q();
    @(negedge clk);
    i_b_full = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_lane_full got %b exp 1", o_ready); end
    i_a_full = 1'b1; i_valid = 1'b1; i_data = 32'd11; i_last = 1'b0;
    #1;
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low got %b exp 0", o_ready); end
    repeat (3) @(negedge clk);
    checks++; if (got_a_q.size() != 0 || o_ready !== 1'b0) begin errors++;
      $display("FAIL bp_no_write got %0d words ready %b exp 0 words ready 0", got_a_q.size(), o_ready); end
    i_a_full = 1'b0; i_b_full = 1'b0;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", o_ready); end
    @(posedge clk); #1;
    i_valid = 1'b0;
    send(32'd12, 1'b1);
    i_a_full = 1'b1;      // now in TERM: terminator must wait
    idle(3);
    exp_a_q = '{32'd11, 32'd12};
    checks++; if (!q_eq(got_a_q, exp_a_q)) begin errors++;
      $display("FAIL bp_term_stall got %0d words exp %0d words", got_a_q.size(), exp_a_q.size()); end
    i_a_full = 1'b0;
    idle(3);
    exp_a_q = '{32'd11, 32'd12, 32'd0};
    checks++; if (!q_eq(got_a_q, exp_a_q)) begin errors++;
      $display("FAIL bp_resume got %0d words exp %0d words", got_a_q.size(), exp_a_q.size()); end
    checks++; if (o_runs_a !== 16'd2) begin errors++; $display("FAIL bp_runs_a got %0d exp 2", o_runs_a); end
  endtask

  task automatic test_zero();
    clear_q();
    send(32'd4, 1'b0); send(32'd0, 1'b0); send(32'd6, 1'b1);
    idle(4);
    exp_b_q = '{32'd4, 32'd6, 32'd0};
    checks++; if (!q_eq(got_b_q, exp_b_q)) begin errors++;
      $display("FAIL zero_lane_b got %0d words exp %0d words", got_b_q.size(), exp_b_q.size()); end
    checks++; if (got_a_q.size() != 0) begin errors++; $display("FAIL zero_lane_a_idle got %0d words exp 0", got_a_q.size()); end
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL zero_err got %b exp 1", o_err); end
    checks++; if (o_runs_b !== 16'd2) begin errors++; $display("FAIL zero_runs_b got %0d exp 2", o_runs_b); end
    send(32'd30, 1'b1);
    idle(4);
    exp_a_q = '{32'd30, 32'd0};
    checks++; if (!q_eq(got_a_q, exp_a_q)) begin errors++;
      $display("FAIL zero_next_run got %0d words exp %0d words", got_a_q.size(), exp_a_q.size()); end
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL zero_err_sticky got %b exp 1", o_err); end
  endtask

  task automatic test_flush_balance();
    // Counters are now A=3, B=2, so one empty run must go to B.
    clear_q();
    pulse_flush();
    idle(4);
    exp_b_q = '{32'd0};
    checks++; if (!q_eq(got_b_q, exp_b_q) || got_a_q.size() != 0) begin errors++;
      $display("FAIL flush_pad got %0d/%0d words exp 0/1", got_a_q.size(), got_b_q.size()); end
    checks++; if (o_runs_a !== 16'd3 || o_runs_b !== 16'd3) begin errors++;
      $display("FAIL flush_runs got %0d/%0d exp 3/3", o_runs_a, o_runs_b); end
    checks++; if (o_done !== 1'b1 || o_ready !== 1'b0) begin errors++;
      $display("FAIL flush_done got done %b ready %b exp 1 0", o_done, o_ready); end
    @(negedge clk);
    i_valid = 1'b1; i_data = 32'd40; i_last = 1'b1; i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    idle(3);
    checks++; if (got_a_q.size() != 0 || got_b_q.size() != 1 || o_ready !== 1'b0 || o_done !== 1'b1) begin errors++;
      $display("FAIL done_ignores got %0d/%0d words ready %b done %b exp 0/1 0 1",
               got_a_q.size(), got_b_q.size(), o_ready, o_done); end
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic test_flush_idle();
    do_reset();
    clear_q();
    pulse_flush();
    idle(3);
    checks++; if (got_a_q.size() != 0 || got_b_q.size() != 0) begin errors++;
      $display("FAIL flush_idle_writes got %0d/%0d exp 0/0", got_a_q.size(), got_b_q.size()); end
    checks++; if (o_done !== 1'b1 || o_runs_a !== 16'd0 || o_runs_b !== 16'd0) begin errors++;
      $display("FAIL flush_idle_done got done %b runs %0d/%0d exp 1 0/0", o_done, o_runs_a, o_runs_b); end
  endtask

  task automatic test_flush_open();
    do_reset();
    clear_q();
    send(32'd7, 1'b0);
    @(negedge clk);
    i_valid = 1'b1; i_data = 32'd8; i_last = 1'b0; i_flush = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL flush_same_cycle_ready got %b exp 1", o_ready); end
    @(posedge clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    idle(5);
    exp_a_q = '{32'd7, 32'd8, 32'd0};
    exp_b_q = '{32'd0};
    checks++; if (!q_eq(got_a_q, exp_a_q)) begin errors++;
      $display("FAIL flush_open_a got %0d words exp %0d words", got_a_q.size(), exp_a_q.size()); end
    checks++; if (!q_eq(got_b_q, exp_b_q)) begin errors++;
      $display("FAIL flush_open_b got %0d words exp %0d words", got_b_q.size(), exp_b_q.size()); end
    checks++; if (o_runs_a !== 16'd1 || o_runs_b !== 16'd1 || o_done !== 1'b1) begin errors++;
      $display("FAIL flush_open_state got %0d/%0d done %b exp 1/1 1", o_runs_a, o_runs_b, o_done); end
  endtask

  task automatic test_reset_in_term();
    logic exp_err;
`ifdef RUN_FEEDER_ORDER_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_reset();
    clear_q();
    send(32'd5, 1'b1);
    i_a_full = 1'b1;      // hold in TERM
    idle(2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({o_a_wr, o_b_wr, o_done, o_err, o_ready} !== 5'b00000 || o_runs_a !== 16'd0) begin errors++;
      $display("FAIL rst_term_outputs got %b runs_a %0d exp 00000 0",
               {o_a_wr, o_b_wr, o_done, o_err, o_ready}, o_runs_a); end
    rst = 1'b0; i_a_full = 1'b0;
    idle(2);
    exp_a_q = '{32'd5};
    checks++; if (!q_eq(got_a_q, exp_a_q)) begin errors++;
      $display("FAIL rst_term_discard got %0d words exp 1", got_a_q.size()); end
    clear_q();
    send(32'd9, 1'b0); send(32'd4, 1'b1);
    idle(4);
    exp_a_q = '{32'd9, 32'd4, 32'd0};
    checks++; if (!q_eq(got_a_q, exp_a_q) || got_b_q.size() != 0) begin errors++;
      $display("FAIL rst_lane_a got %0d/%0d words exp 3/0", got_a_q.size(), got_b_q.size()); end
    checks++; if (o_err !== exp_err) begin errors++; $display("FAIL order_err got %b exp %b", o_err, exp_err); end
    checks++; if (both_wr_seen !== 1'b0) begin errors++; $display("FAIL dual_lane_write got 1 exp 0"); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_flush = 1'b0;
    i_a_full = 1'b0; i_b_full = 1'b0; i_data = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero();
    test_flush_balance();
    test_flush_idle();
    test_flush_open();
    test_reset_in_term();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
